// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC infrared receiver: FSM states, default
// pulse-width thresholds in 10 us ticks, and the frame integrity check.
package nec_ir_pkg;

    localparam int TICK_W     = 10;
    localparam int FRAME_BITS = 32;
    localparam int BIT_CNT_W  = 6;

    localparam int unsigned LEAD_MARK_MIN_DEF  = 800;
    localparam int unsigned LEAD_SPACE_MIN_DEF = 350;
    localparam int unsigned LEAD_SPACE_MAX_DEF = 600;
    localparam int unsigned MARK_MAX_DEF       = 100;
    localparam int unsigned BIT_ONE_MIN_DEF    = 112;
    localparam int unsigned SPACE_MAX_DEF      = 250;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4
    } nec_state_e;

    // Word layout is {~cmd, cmd, ~addr, addr}; both bytes must match their complements.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] w);
        return (w[15:8] == ~w[7:0]) && (w[31:24] == ~w[23:16]);
    endfunction

endpackage

// File: rtl/ir_sync_edge.sv
// Two-flop synchronizer for the asynchronous IR input plus a third flop that
// turns level changes into single-cycle fall and rise pulses.
module ir_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic ir,
    output logic fall,
    output logic rise
);

    logic ir_p0;
    logic ir_p1;
    logic ir_p2;

    // Presetting to 1 keeps the idle line from producing a spurious fall after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_p0 <= 1'b1;
            ir_p1 <= 1'b1;
            ir_p2 <= 1'b1;
        end else begin
            ir_p0 <= ir;
            ir_p1 <= ir_p0;
            ir_p2 <= ir_p1;
        end
    end

    assign fall = ir_p2 & ~ir_p1;
    assign rise = ~ir_p2 & ir_p1;

endmodule

// File: rtl/nec_ir_rx.sv
// NEC infrared frame receiver: times marks and spaces in 10 us ticks, shifts in
// the 32-bit LSB-first frame and presents {address, command} on DO with READY.
module nec_ir_rx
    import nec_ir_pkg::*;
#(
    parameter int unsigned LEAD_MARK_MIN  = LEAD_MARK_MIN_DEF,
    parameter int unsigned LEAD_SPACE_MIN = LEAD_SPACE_MIN_DEF,
    parameter int unsigned LEAD_SPACE_MAX = LEAD_SPACE_MAX_DEF,
    parameter int unsigned MARK_MAX       = MARK_MAX_DEF,
    parameter int unsigned BIT_ONE_MIN    = BIT_ONE_MIN_DEF,
    parameter int unsigned SPACE_MAX      = SPACE_MAX_DEF
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        CLK_10U,
    input  logic        CS,
    input  logic        IR,
    output logic        READY,
    output logic [15:0] DO
);

    localparam logic [TICK_W-1:0]    LM_MIN   = TICK_W'(LEAD_MARK_MIN);
    localparam logic [TICK_W-1:0]    LS_MIN   = TICK_W'(LEAD_SPACE_MIN);
    localparam logic [TICK_W-1:0]    LS_MAX   = TICK_W'(LEAD_SPACE_MAX);
    localparam logic [TICK_W-1:0]    BM_MAX   = TICK_W'(MARK_MAX);
    localparam logic [TICK_W-1:0]    ONE_MIN  = TICK_W'(BIT_ONE_MIN);
    localparam logic [TICK_W-1:0]    BS_MAX   = TICK_W'(SPACE_MAX);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    function automatic logic [TICK_W-1:0] sat_inc(input logic [TICK_W-1:0] v);
        return (v == {TICK_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic                    ir_fall;
    logic                    ir_rise;
    nec_state_e              state;
    nec_state_e              state_nxt;
    logic [TICK_W-1:0]       cnt;
    logic                    cnt_clr;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [BIT_CNT_W-1:0]    bit_cnt_nxt;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   shift_nxt;
    logic [FRAME_BITS-1:0]   shifted;
    logic                    frame_done;

    ir_sync_edge u_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .ir    (IR),
        .fall  (ir_fall),
        .rise  (ir_rise)
    );

    // Frame is LSB first, so each new bit enters at the MSB and the word shifts right.
    assign shifted = {(cnt >= ONE_MIN), shift_q[FRAME_BITS-1:1]};

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_q;
        frame_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ir_fall) state_nxt = ST_LEAD_MARK;
            end
            ST_LEAD_MARK: begin
                if (ir_rise) state_nxt = (cnt >= LM_MIN) ? ST_LEAD_SPACE : ST_IDLE;
            end
            ST_LEAD_SPACE: begin
                if (ir_fall) begin
                    if (cnt >= LS_MIN) begin
                        state_nxt   = ST_BIT_MARK;
                        bit_cnt_nxt = '0;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (cnt >= LS_MAX) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BIT_MARK: begin
                if (ir_rise) state_nxt = (cnt <= BM_MAX) ? ST_BIT_SPACE : ST_IDLE;
            end
            ST_BIT_SPACE: begin
                if (ir_fall) begin
                    shift_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        frame_done = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        state_nxt = ST_BIT_MARK;
                    end
                end else if (cnt >= BS_MAX) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        cnt_clr = ir_fall | ir_rise | (state_nxt != state);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shift_q <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            shift_q <= shift_nxt;
            if (cnt_clr)
                cnt <= '0;
            else if (CLK_10U)
                cnt <= sat_inc(cnt);
        end
    end

    // A completing good frame takes priority over a simultaneous CS read.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            READY <= 1'b0;
            DO    <= '0;
        end else if (frame_done && frame_ok(shifted)) begin
            READY <= 1'b1;
            DO    <= {shifted[7:0], shifted[23:16]};
        end else if (CS) begin
            READY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nec_ir_rx.sv
// Directed NEC frames with a scoreboard: expected DO words are queued as frames
// are sent and a monitor compares them whenever READY rises.
module tb_nec_ir_rx;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        CLK_10U = 1'b0;
    logic        CS;
    logic        IR;
    logic        READY;
    logic [15:0] DO;

    int          errors = 0;
    int          checks = 0;
    int          tick_div = 4;
    int          tick_cnt = 0;
    logic [15:0] sb_q[$];
    logic        ready_q = 1'b0;

    nec_ir_rx dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .CLK_10U (CLK_10U),
        .CS      (CS),
        .IR      (IR),
        .READY   (READY),
        .DO      (DO)
    );

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(negedge CLK);
            tick_cnt = tick_cnt + 1;
            if (tick_cnt >= tick_div) tick_cnt = 0;
            CLK_10U = (tick_cnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every rising READY must match the oldest queued expectation.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (READY === 1'b1 && ready_q !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ready: got DO=%h expected no frame", DO);
                end else begin
                    check("scoreboard_do", {16'h0, DO}, {16'h0, sb_q.pop_front()});
                end
            end
            ready_q = READY;
        end
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge CLK);
            if (CLK_10U) k++;
        end
        #1;
    endtask

    task automatic mark(input int n);
        IR = 1'b0;
        ticks(n);
        IR = 1'b1;
    endtask

    task automatic leader(input int space);
        mark(900);
        ticks(space);
    endtask

    task automatic bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            mark(56);
            ticks(w[i] ? 169 : 56);
        end
    endtask

    task automatic stop_mark(input bit ok, input logic [15:0] exp_do);
        logic got = 1'b0;
        if (ok) sb_q.push_back(exp_do);
        IR = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge CLK);
            #1;
            if (READY) got = 1'b1;
        end
        check(ok ? "ready_latency" : "no_ready", {31'h0, got}, {31'h0, ok});
        ticks(56);
        IR = 1'b1;
        ticks(30);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    task automatic send_frame(input logic [31:0] w, input bit ok, input logic [15:0] exp_do);
        leader(450);
        bits(w, 32);
        stop_mark(ok, exp_do);
    endtask

    task automatic cs_pulse(input logic [15:0] exp_do);
        @(negedge CLK);
        CS = 1'b1;
        @(negedge CLK);
        CS = 1'b0;
        check("cs_clears_ready", {31'h0, READY}, 32'h0);
        check("cs_keeps_do", {16'h0, DO}, {16'h0, exp_do});
    endtask

    initial begin
        IR      = 1'b1;
        CS      = 1'b0;
        RESET_N = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("reset_ready", {31'h0, READY}, 32'h0);
        check("reset_do", {16'h0, DO}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (10) @(posedge CLK);
        #1;

        // Nominal frame at one tick per 4 CLK.
        send_frame(32'hAA5533CC, 1'b1, 16'hCC55);
        check("nominal_ready_held", {31'h0, READY}, 32'h1);
        cs_pulse(16'hCC55);

        tick_div = 1;

        // Address complement broken: frame dropped.
        send_frame(32'hAA5533CD, 1'b0, 16'h0);
        check("bad_frame_ready", {31'h0, READY}, 32'h0);
        check("bad_frame_do", {16'h0, DO}, 32'h0000CC55);

        // Repeat code, then a valid frame.
        leader(225);
        mark(56);
        ticks(50);
        check("repeat_ready", {31'h0, READY}, 32'h0);
        send_frame(32'hFE01FF00, 1'b1, 16'h0001);
        cs_pulse(16'h0001);

        // Short glitch leader, then a valid frame left unread.
        mark(300);
        ticks(100);
        send_frame(32'hFF0000FF, 1'b1, 16'hFF00);
        check("glitch_do", {16'h0, DO}, 32'h0000FF00);

        // Reset mid-frame after 10 bits.
        leader(450);
        bits(32'hAA5533CC, 10);
        @(negedge CLK);
        RESET_N = 1'b0;
        @(posedge CLK);
        #1;
        check("midreset_ready", {31'h0, READY}, 32'h0);
        check("midreset_do", {16'h0, DO}, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        ticks(20);
        send_frame(32'hBF40DF20, 1'b1, 16'h2040);
        cs_pulse(16'h2040);

        // Space held 300 ticks before the last bit: frame must abort.
        leader(450);
        bits(32'hAA5533CC, 31);
        mark(56);
        ticks(300);
        stop_mark(1'b0, 16'h0);
        check("timeout_do", {16'h0, DO}, 32'h00002040);

        check("final_queue_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
